// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sevensegments_scanner_if.sv
// Display-side bundle: hex word load strobe in, scanned pins and frame out.
// The scanner takes the slave side.
interface sevensegments_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                frame;

    modport master (
        output value, load,
        input  seg, an, frame
    );

    modport slave (
        input  value, load,
        output seg, an, frame
    );
endinterface

// File: rtl/hex_to_segments.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_segments
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = GLYPHS[hex];

endmodule

// File: rtl/sevensegments_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with guard slots.
// Optional leading-zero blanking when SEVSEG_LZB_EN is defined.
module sevensegments_scanner
    import sevenseg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    sevensegments_scanner_if.slave bus
);

    localparam int CNT_MAX = max2(REFRESH_DIV, GUARD_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    scan_state_t         state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [4*DIGITS-1:0] staging, shadow;
    logic                pending;
    logic                boundary;
    logic [6:0]          seg_q, seg_n;
    logic [DIGITS-1:0]   an_q, an_n;
    logic                frame_q;
    logic [3:0]          digit;
    logic [6:0]          glyph;
    logic                blank;

    assign digit = shadow[4*idx +: 4];

    hex_to_segments u_glyph (
        .hex (digit),
        .seg (glyph)
    );

`ifdef SEVSEG_LZB_EN
    logic [IDX_W-1:0] top;

    // Highest nonzero digit; an all-zero word still keeps digit 0 lit.
    always_comb begin
        top = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (shadow[4*i +: 4] != 4'h0) top = IDX_W'(i);
        end
    end

    assign blank = (idx > top);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CNT_W'(1);
        idx_n    = idx;
        boundary = 1'b0;
        unique case (state)
            GUARD: begin
                if (cnt == G_LAST) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                end
            end
            DRIVE: begin
                if (cnt == R_LAST) begin
                    state_n  = GUARD;
                    cnt_n    = '0;
                    boundary = (idx == IDX_LAST);
                    idx_n    = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
        endcase
    end

    // Pins follow the next state so they change on the same edge.
    always_comb begin
        seg_n = SEG_OFF;
        an_n  = '1;
        if (state_n == DRIVE && !blank) begin
            seg_n = glyph;
            an_n  = ~(DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= GUARD;
            cnt     <= '0;
            idx     <= '0;
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            seg_q   <= seg_n;
            an_q    <= an_n;
            frame_q <= boundary;
            if (bus.load) staging <= bus.value;
            if (boundary && bus.load) begin
                shadow  <= bus.value;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                shadow  <= staging;
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_sevensegments_scanner.sv
// Self-checking bench: timeline reference model plus table-driven frames.
module tb_sevensegments_scanner;

    localparam int D = 4;
    localparam int R = 4;
    localparam int G = 1;
    localparam int P = R + G;
    localparam int F = D * P;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sevensegments_scanner_if #(.DIGITS(D)) bus ();

    sevensegments_scanner #(
        .DIGITS       (D),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: cycle count since reset plus load bookkeeping.
    int          k = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_staging = '0;
    bit          m_pending = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        if (reset) begin
            k = 0;
            m_shadow = '0;
            m_staging = '0;
            m_pending = 0;
        end else begin
            k++;
            if (bus.load) begin
                if (k % F == 0) begin
                    m_shadow = bus.value;
                    m_pending = 0;
                end else begin
                    m_pending = 1;
                end
                m_staging = bus.value;
            end else if (k % F == 0 && m_pending) begin
                m_shadow = m_staging;
                m_pending = 0;
            end
        end
    end

    function automatic int top_digit(input logic [15:0] v);
        int t = 0;
        for (int i = 0; i < D; i++)
            if (((v >> (4 * i)) & 16'hF) != 0) t = i;
        return t;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic [3:0] nib;
            int d;
            e_an = 4'hF;
            e_seg = 7'h7F;
            if (k % P >= G) begin
                d = (k / P) % D;
                nib = 4'((m_shadow >> (4 * d)) & 16'hF);
                e_an = ~(4'b1 << d);
                e_seg = glyph_tab[nib];
`ifdef SEVSEG_LZB_EN
                if (d > top_digit(m_shadow)) begin
                    e_an = 4'hF;
                    e_seg = 7'h7F;
                end
`endif
            end
            chk("model_an", 32'(bus.an), 32'(e_an));
            chk("model_seg", 32'(bus.seg), 32'(e_seg));
            chk("model_frame", 32'(bus.frame), 32'(k > 0 && k % F == 0));
        end
    end

    typedef struct {
        int          mode;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [6:0]  e [4];
    } vec_t;

    vec_t tab [6];

    task automatic setv(input int i, input int mode, input logic [15:0] v1,
                        input logic [15:0] v2, input logic [6:0] e0,
                        input logic [6:0] e1, input logic [6:0] e2,
                        input logic [6:0] e3);
        tab[i].mode = mode;
        tab[i].v1 = v1;
        tab[i].v2 = v2;
        tab[i].e[0] = e0;
        tab[i].e[1] = e1;
        tab[i].e[2] = e2;
        tab[i].e[3] = e3;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bus.value = v;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while (!bus.frame && n < 2 * F + 5) begin
            @(negedge clk);
            n++;
        end
        if (!bus.frame) begin
            errors++;
            vectors++;
            $display("FAIL %s: frame pulse timeout", name);
        end
    endtask

    // Called on the frame-pulse sample; grabs each digit's DRIVE glyph.
    task automatic capture(input int i);
        int off = 0;
        for (int d = 0; d < D; d++) begin
            repeat (G + d * P - off) @(negedge clk);
            off = G + d * P;
            chk($sformatf("tab%0d_d%0d", i, d), 32'(bus.seg), 32'(tab[i].e[d]));
        end
    endtask

    initial begin
        bus.load = 1'b0;
        bus.value = '0;

        setv(0, 0, 16'h1234, 0, 7'h19, 7'h30, 7'h24, 7'h79);
        setv(1, 0, 16'hABCD, 0, 7'h21, 7'h46, 7'h03, 7'h08);
        setv(2, 1, 16'hFFFF, 0, 7'h0E, 7'h0E, 7'h0E, 7'h0E);
        setv(3, 2, 16'h1111, 16'h2222, 7'h24, 7'h24, 7'h24, 7'h24);
`ifdef SEVSEG_LZB_EN
        setv(4, 0, 16'h0000, 0, 7'h40, 7'h7F, 7'h7F, 7'h7F);
        setv(5, 0, 16'h0042, 0, 7'h24, 7'h19, 7'h7F, 7'h7F);
`else
        setv(4, 0, 16'h0000, 0, 7'h40, 7'h40, 7'h40, 7'h40);
        setv(5, 0, 16'h0042, 0, 7'h24, 7'h19, 7'h40, 7'h40);
`endif

        repeat (3) @(negedge clk);
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_seg", 32'(bus.seg), 32'h7F);
        chk("reset_frame", 32'(bus.frame), 32'h0);
        chk_en = 1;

        reset = 1'b0;
        #1;
        chk("rel_an", 32'(bus.an), 32'hF);
        chk("rel_seg", 32'(bus.seg), 32'h7F);
        for (int c = 0; c < R; c++) begin
            @(negedge clk);
            chk("first_an", 32'(bus.an), 32'hE);
            chk("first_seg", 32'(bus.seg), 32'h40);
        end
        @(negedge clk);
        chk("first_guard_an", 32'(bus.an), 32'hF);

        for (int i = 0; i < 6; i++) begin
            case (tab[i].mode)
                0: begin
                    repeat ($urandom_range(0, F - 1)) @(negedge clk);
                    pulse_load(tab[i].v1);
                end
                1: begin
                    pulse_load(16'h0000);
                    wait_frame("prep_frame");
                    @(negedge clk);
                    while ((k + 1) % F != 0) @(negedge clk);
                    pulse_load(tab[i].v1);
                end
                default: begin
                    wait_frame("dbl_frame");
                    repeat (2) @(negedge clk);
                    pulse_load(tab[i].v1);
                    repeat (3) @(negedge clk);
                    pulse_load(tab[i].v2);
                end
            endcase
            wait_frame($sformatf("tab%0d_frame", i));
            capture(i);
            @(negedge clk);
        end

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.value = 16'($urandom);
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;

        repeat (7) @(negedge clk);
        pulse_load(16'h9876);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.value = 16'($urandom);
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
